cpu_bus_unit: RTL and testbench
===============================

Name: cpu_bus_unit

Overview:
Parametrised fetch/load-store bus sequencer for the NES CPU core. It arbitrates one single-port synchronous memory bus between instruction prefetch and load/store requests, and buffers prefetched bytes in a PF_DEPTH-entry FIFO. The core consumes the FIFO through a valid/ready port and redirects the PC on branches. Bus tristating is done at top level, not here.

Parameters:
ADDR_W, 16, bus address width
DATA_W, 8, bus data width
PF_DEPTH, 4, prefetch FIFO entries; power of 2, 2..16
RESET_PC, 16'h0000, PC after reset when CPU_BUS_RSTVEC_EN is undefined
VEC_ADDR, 16'hFFFC, reset-vector low-byte address (macro builds only)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
bus_addr  out  ADDR_W  memory address for the current cycle
bus_en  out  1  access valid this cycle
bus_rw_n  out  1  1 = read, 0 = write
bus_wdata  out  DATA_W  write data
bus_rdata  in  DATA_W  read data; valid the cycle after the access
if_valid  out  1  FIFO head valid
if_data  out  DATA_W  FIFO head byte
if_pc  out  ADDR_W  address of FIFO head byte
if_ready  in  1  pop head when if_valid & if_ready
pc_load  in  1  redirect fetch
pc_new  in  ADDR_W  redirect target
ls_req  in  1  load/store request, held until ls_ack
ls_we  in  1  1 = store
ls_addr  in  ADDR_W  load/store address
ls_wdata  in  DATA_W  store data
ls_ack  out  1  one-cycle completion pulse
ls_rdata  out  DATA_W  load data, valid with ls_ack

Behaviour:
- Reset (async assert): FIFO empty, if_valid 0, ls_ack 0, bus_en 0, bus_rw_n 1, bus_wdata 0, pending slot empty, epoch 0, PC = RESET_PC. bus_addr = PC while idle.
- Bus timing: bus_* are combinational from state. Memory samples at the end of cycle N, and bus_rdata is valid in cycle N+1. At most one access is pending; it retires in N+1.
- Slot choice per cycle (RUN state), in priority order:
  1. LS when ls_req and no LS pending.
  2. FETCH when occupancy + pending fetch < PF_DEPTH and pc_load is low.
  3. Otherwise idle: bus_en 0.
- LS issue: bus_addr = ls_addr, bus_rw_n = ~ls_we. ls_ack is high in N+1, with ls_rdata = bus_rdata for loads (don't-care for stores). ls_req is never issued in its own ack cycle. The requester updates or drops ls_req on the edge ending the ack cycle. Throughput is one LS per 2 cycles.
- FETCH issue: bus_addr = PC, then PC <= PC+1, wrapping modulo 2^ADDR_W. In N+1 the byte is pushed with its address, tagged with the issue epoch. if_valid rises in N+2. Fetch-to-fetch throughput is 1/cycle.
- FIFO: push and pop in the same cycle are allowed, even when full, since the pop frees space. Push never overflows because of the issue condition. Pop while empty is ignored.
- pc_load (cycle N):
  - FIFO flushed at end of N; PC <= pc_new; epoch toggles.
  - A fetch returning in N is discarded.
  - No fetch issues in N. An LS may issue in N.
  - First fetch from pc_new is in N+1.
  - pc_load has priority over pop and push in the same cycle.
- No state depends on ls_req while an LS is pending. Reset asserted mid-access aborts everything immediately, with no ls_ack.

Optional Feature:
CPU_BUS_RSTVEC_EN.
- Defined: after reset the FSM runs VEC_LO -> VEC_HI -> RUN.
  - VEC_LO reads VEC_ADDR; VEC_HI reads VEC_ADDR+1.
  - PC = {hi, lo}, where the hi byte is captured in the cycle after VEC_HI.
  - No FETCH or LS issues until RUN; ls_req waits.
  - The first fetch is 3 cycles after reset release.
  - Requires ADDR_W == 2*DATA_W (elaboration error otherwise).
  - pc_load during VEC states is ignored.
- Undefined: the FSM starts in RUN with PC = RESET_PC, and VEC_ADDR is unused.

Decomposition:
- Package cpu_bus_pkg holds:
  - state enum {VEC_LO, VEC_HI, RUN}
  - pending-kind enum {NONE, FETCH, LOAD, STORE}
  - default widths
- Sub-module: cpu_bus_fifo, a parametrised sync FIFO (width DATA_W+ADDR_W, depth PF_DEPTH) with flush, push, pop, count, and full/empty outputs.

Test Plan:
- Reset release, RESET_PC=0x0000, memory[i]=i, if_ready=1 -> bus_addr 0,1,2,... on consecutive cycles; if_valid from cycle 2; if_data/if_pc = 0x00/0x0000, 0x01/0x0001, ...
- if_ready=0 with PF_DEPTH=4 -> exactly 4 fetches issued, bus_en then 0, FIFO holds 0..3. Raise if_ready for 1 cycle -> one pop and one new fetch at 0x0004.
- Store (ls_addr 0x0200, 0x5A) during streaming fetch -> LS wins that cycle, bus_rw_n=0, ls_ack next cycle. A following load from 0x0200 returns ls_rdata 0x5A; fetch PC is not advanced by LS cycles.
- pc_load pc_new=0x8000 while a fetch of 0x0005 is pending and the FIFO is non-empty -> FIFO empties, the 0x0005 byte is dropped, the next bus_addr is 0x8000, and if_pc=0x8000 is first out.
- PC 0xFFFF fetch -> next fetch at 0x0000, and if_pc shows 0xFFFF then 0x0000.
- With CPU_BUS_RSTVEC_EN, mem[0xFFFC]=0x34, mem[0xFFFD]=0x12 -> bus reads 0xFFFC, 0xFFFD, then the first fetch at 0x1234. ls_req held from reset is issued only after the RUN state is reached.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared types and default widths for the NES CPU bus unit.
// Sequencer states, pending-access kinds, default parameter values.
package cpu_bus_pkg;

  localparam int DEF_ADDR_W   = 16;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_PF_DEPTH = 4;

  typedef enum logic [1:0] {
    VEC_LO,
    VEC_HI,
    RUN
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    FETCH,
    LOAD,
    STORE
  } pend_t;

endpackage

// File: rtl/cpu_bus_fifo.sv
// cpu_bus_fifo: synchronous prefetch FIFO with flush.
// Pop on empty is ignored; push on full is accepted when a pop frees space.
module cpu_bus_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp];

  // storage write
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wp] <= din;
  end

  // pointers and occupancy; flush wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/cpu_bus_unit.sv
// cpu_bus_unit: fetch/load-store sequencer for one single-port bus.
// CPU_BUS_RSTVEC_EN: load PC from the reset vector before running.
import cpu_bus_pkg::*;

module cpu_bus_unit #(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                PF_DEPTH = DEF_PF_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
  parameter logic [ADDR_W-1:0] VEC_ADDR = 16'hFFFC
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_en,
  output logic              bus_rw_n,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_data,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              if_ready,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_new,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ack,
  output logic [DATA_W-1:0] ls_rdata
);

  localparam int CW = $clog2(PF_DEPTH) + 1;
  localparam int FW = CW + 1;
`ifdef CPU_BUS_RSTVEC_EN
  localparam state_t START_ST = VEC_LO;
`else
  localparam state_t START_ST = RUN;
`endif

  state_t            state, state_nx;
  pend_t             pend, pend_nx;
  logic [ADDR_W-1:0] pc, pend_addr, vec_pc;
  logic              epoch, pend_ep, vec_cap;
  logic              run, redirect, ls_busy;
  logic              f_issue, f_room;
  logic              push, pop, full, empty;
  logic [CW-1:0]     count;
  logic [FW-1:0]     fill;

  assign run      = (state == RUN) && !vec_cap;
  assign redirect = run && pc_load;
  assign ls_busy  = (pend == LOAD) || (pend == STORE);
  assign fill     = FW'(count) + FW'(pend == FETCH);
  assign f_room   = fill < FW'(PF_DEPTH);

`ifdef CPU_BUS_RSTVEC_EN
  logic [DATA_W-1:0] vec_lo;

  if (ADDR_W != 2 * DATA_W) begin : g_vec_chk
    $error("CPU_BUS_RSTVEC_EN needs ADDR_W == 2*DATA_W");
  end

  // low byte returns during VEC_HI; high byte one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_lo  <= '0;
      vec_cap <= 1'b0;
    end else begin
      if (state == VEC_HI) vec_lo <= bus_rdata;
      vec_cap <= (state == VEC_HI);
    end
  end

  assign vec_pc = {bus_rdata, vec_lo};
`else
  assign vec_cap = 1'b0;
  assign vec_pc  = RESET_PC;
`endif

  // slot choice and bus drive; nothing issues while in reset
  always_comb begin
    state_nx  = state;
    pend_nx   = NONE;
    f_issue   = 1'b0;
    bus_en    = 1'b0;
    bus_rw_n  = 1'b1;
    bus_wdata = '0;
    bus_addr  = pc;
    if (rst_n) begin
      unique case (state)
        VEC_LO: begin
          bus_en   = 1'b1;
          bus_addr = VEC_ADDR;
          state_nx = VEC_HI;
        end
        VEC_HI: begin
          bus_en   = 1'b1;
          bus_addr = VEC_ADDR + ADDR_W'(1);
          state_nx = RUN;
        end
        RUN: begin
          if (!vec_cap) begin
            if (ls_req && !ls_busy) begin
              pend_nx  = ls_we ? STORE : LOAD;
              bus_en   = 1'b1;
              bus_rw_n = ~ls_we;
              bus_addr = ls_addr;
              if (ls_we) bus_wdata = ls_wdata;
            end else if (f_room && !pc_load) begin
              f_issue = 1'b1;
              pend_nx = FETCH;
              bus_en  = 1'b1;
            end
          end
        end
        default: state_nx = RUN;
      endcase
    end
  end

  // state, pending slot, PC and epoch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= START_ST;
      pend      <= NONE;
      pend_addr <= '0;
      pend_ep   <= 1'b0;
      pc        <= RESET_PC;
      epoch     <= 1'b0;
    end else begin
      state <= state_nx;
      pend  <= pend_nx;
      if (f_issue) begin
        pend_addr <= pc;
        pend_ep   <= epoch;
      end
      if (vec_cap) begin
        pc <= vec_pc;
      end else if (redirect) begin
        pc    <= pc_new;
        epoch <= ~epoch;
      end else if (f_issue) begin
        pc <= pc + 1'b1;
      end
    end
  end

  assign pop  = if_ready && !redirect;
  assign push = (pend == FETCH) && (pend_ep == epoch) && !redirect
             && (!full || (pop && !empty));

  cpu_bus_fifo #(
    .W     (DATA_W + ADDR_W),
    .DEPTH (PF_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect),
    .push  (push),
    .din   ({pend_addr, bus_rdata}),
    .pop   (pop),
    .dout  ({if_pc, if_data}),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign if_valid = !empty;
  assign ls_ack   = ls_busy;
  assign ls_rdata = bus_rdata;

endmodule

// File: tb/tb_cpu_bus_unit.sv
// tb_cpu_bus_unit: directed and randomized checks of cpu_bus_unit.
// Bench memory answers the bus; a request-level model predicts results.
module tb_cpu_bus_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] bus_addr;
  logic        bus_en, bus_rw_n;
  logic [7:0]  bus_wdata, bus_rdata;
  logic        if_valid, if_ready;
  logic [7:0]  if_data;
  logic [15:0] if_pc;
  logic        pc_load;
  logic [15:0] pc_new;
  logic        ls_req, ls_we, ls_ack;
  logic [15:0] ls_addr;
  logic [7:0]  ls_wdata, ls_rdata;

  logic [7:0]  mem [65536];
  logic [7:0]  ref_mem [65536];
  logic [7:0]  rdq;
  int          n_chk = 0;
  int          n_fail = 0;

  cpu_bus_unit dut (
    .clk(clk), .rst_n(rst_n),
    .bus_addr(bus_addr), .bus_en(bus_en), .bus_rw_n(bus_rw_n),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .if_valid(if_valid), .if_data(if_data), .if_pc(if_pc),
    .if_ready(if_ready), .pc_load(pc_load), .pc_new(pc_new),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_ack(ls_ack), .ls_rdata(ls_rdata)
  );

  always #5 clk = ~clk;

  assign bus_rdata = rdq;

  always @(posedge clk) begin
    if (bus_en) begin
      if (!bus_rw_n) mem[bus_addr] <= bus_wdata;
      rdq <= mem[bus_addr];
    end
  end

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0];
  endfunction

  task automatic mem_init();
    for (int i = 0; i < 65536; i++) begin
      mem[i] = pat(16'(i));
      ref_mem[i] = pat(16'(i));
    end
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h00;
    ref_mem[16'hFFFC] = 8'h00; ref_mem[16'hFFFD] = 8'h00;
  endtask

  task automatic drive_idle();
    ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0;
    pc_load = 0; pc_new = '0; if_ready = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1;
`ifdef CPU_BUS_RSTVEC_EN
    repeat (3) @(negedge clk);
`endif
  endtask

  task automatic test_reset();
    drive_idle();
    @(negedge clk); rst_n = 0;
    #1;
    n_chk++; if (bus_en !== 1'b0) begin n_fail++; $display("FAIL rst_bus_en got %b exp 0", bus_en); end
    n_chk++; if (bus_rw_n !== 1'b1) begin n_fail++; $display("FAIL rst_rw_n got %b exp 1", bus_rw_n); end
    n_chk++; if (bus_wdata !== 8'h00) begin n_fail++; $display("FAIL rst_wdata got %h exp 00", bus_wdata); end
    n_chk++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_if_valid got %b exp 0", if_valid); end
    n_chk++; if (ls_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ls_ack got %b exp 0", ls_ack); end
    n_chk++; if (bus_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_addr got %h exp 0000", bus_addr); end
    do_reset();
    ls_req = 1; ls_we = 1; ls_addr = 16'h0377; ls_wdata = 8'h77;
    #1;
    n_chk++; if (bus_en !== 1'b1 || bus_rw_n !== 1'b0) begin n_fail++; $display("FAIL abort_issue got en=%b rw_n=%b exp 1/0", bus_en, bus_rw_n); end
    @(posedge clk); #1 rst_n = 0;
    #1;
    n_chk++; if (ls_ack !== 1'b0) begin n_fail++; $display("FAIL abort_ack got %b exp 0", ls_ack); end
    drive_idle();
  endtask

  task automatic test_stream();
    do_reset();
    if_ready = 1;
    for (int c = 0; c < 10; c++) begin
      #1;
      n_chk++; if (bus_en !== 1'b1 || bus_addr !== 16'(c)) begin n_fail++; $display("FAIL stream_addr c=%0d got %b/%h exp 1/%h", c, bus_en, bus_addr, 16'(c)); end
      n_chk++; if (if_valid !== (c >= 2)) begin n_fail++; $display("FAIL stream_valid c=%0d got %b exp %b", c, if_valid, c >= 2); end
      if (c >= 2) begin
        n_chk++; if (if_pc !== 16'(c - 2) || if_data !== pat(16'(c - 2))) begin n_fail++; $display("FAIL stream_head c=%0d got %h/%h exp %h/%h", c, if_pc, if_data, 16'(c - 2), pat(16'(c - 2))); end
      end
      @(negedge clk);
    end
    drive_idle();
  endtask

  task automatic test_backpressure();
    int nf;
    do_reset();
    if_ready = 0; nf = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (bus_en) begin
        n_chk++; if (bus_addr !== 16'(nf)) begin n_fail++; $display("FAIL bp_addr got %h exp %h", bus_addr, 16'(nf)); end
        nf++;
      end
      @(negedge clk);
    end
    n_chk++; if (nf != 4) begin n_fail++; $display("FAIL bp_fetches got %0d exp 4", nf); end
    if_ready = 1;
    #1;
    n_chk++; if (if_valid !== 1'b1 || if_pc !== 16'h0000) begin n_fail++; $display("FAIL bp_head got %b/%h exp 1/0000", if_valid, if_pc); end
    n_chk++; if (bus_en !== 1'b0) begin n_fail++; $display("FAIL bp_full_en got %b exp 0", bus_en); end
    @(negedge clk);
    if_ready = 0; nf = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (bus_en) begin
        n_chk++; if (bus_addr !== 16'h0004) begin n_fail++; $display("FAIL bp_refill got %h exp 0004", bus_addr); end
        nf++;
      end
      @(negedge clk);
    end
    n_chk++; if (nf != 1) begin n_fail++; $display("FAIL bp_refill_cnt got %0d exp 1", nf); end
    if_ready = 1;
    for (int k = 1; k <= 4; k++) begin
      #1;
      n_chk++; if (if_valid !== 1'b1 || if_pc !== 16'(k) || if_data !== pat(16'(k))) begin n_fail++; $display("FAIL bp_drain got %b/%h/%h exp 1/%h/%h", if_valid, if_pc, if_data, 16'(k), pat(16'(k))); end
      @(negedge clk);
    end
    drive_idle();
  endtask

  task automatic test_ls();
    logic [15:0] exp;
    do_reset();
    if_ready = 1; exp = 16'h0000;
    ls_addr = 16'h0200; ls_wdata = 8'h5A;
    for (int c = 0; c < 12; c++) begin
      ls_req = (c >= 3 && c <= 6);
      ls_we = (c <= 4);
      #1;
      if (c == 3) begin
        n_chk++; if (bus_en !== 1'b1 || bus_rw_n !== 1'b0 || bus_addr !== 16'h0200 || bus_wdata !== 8'h5A) begin n_fail++; $display("FAIL st_issue got %b/%b/%h/%h exp 1/0/0200/5a", bus_en, bus_rw_n, bus_addr, bus_wdata); end
        n_chk++; if (ls_ack !== 1'b0) begin n_fail++; $display("FAIL st_early_ack got %b exp 0", ls_ack); end
        ref_mem[16'h0200] = 8'h5A;
      end
      if (c == 4) begin
        n_chk++; if (ls_ack !== 1'b1 || bus_addr !== 16'h0003 || bus_rw_n !== 1'b1) begin n_fail++; $display("FAIL st_ack got %b/%h/%b exp 1/0003/1", ls_ack, bus_addr, bus_rw_n); end
      end
      if (c == 5) begin
        n_chk++; if (bus_en !== 1'b1 || bus_rw_n !== 1'b1 || bus_addr !== 16'h0200) begin n_fail++; $display("FAIL ld_issue got %b/%b/%h exp 1/1/0200", bus_en, bus_rw_n, bus_addr); end
      end
      if (c == 6) begin
        n_chk++; if (ls_ack !== 1'b1 || ls_rdata !== ref_mem[16'h0200] || bus_addr !== 16'h0004) begin n_fail++; $display("FAIL ld_ack got %b/%h/%h exp 1/%h/0004", ls_ack, ls_rdata, bus_addr, ref_mem[16'h0200]); end
      end
      if (if_valid) begin
        n_chk++; if (if_pc !== exp || if_data !== ref_mem[exp]) begin n_fail++; $display("FAIL ls_stream got %h/%h exp %h/%h", if_pc, if_data, exp, ref_mem[exp]); end
        exp++;
      end
      @(negedge clk);
    end
    n_chk++; if (exp !== 16'h0008) begin n_fail++; $display("FAIL ls_popped got %h exp 0008", exp); end
    drive_idle();
  endtask

  task automatic test_redirect();
    logic [15:0] exp;
    do_reset();
    if_ready = 1; exp = 16'h0000; pc_new = 16'h8000;
    for (int c = 0; c < 13; c++) begin
      pc_load = (c == 6);
      #1;
      if (c == 6) begin
        n_chk++; if (bus_en !== 1'b0 || if_valid !== 1'b1) begin n_fail++; $display("FAIL rd_cycle got en=%b valid=%b exp 0/1", bus_en, if_valid); end
        exp = 16'h8000;
      end else if (if_valid) begin
        n_chk++; if (if_pc !== exp || if_data !== ref_mem[exp]) begin n_fail++; $display("FAIL rd_stream got %h/%h exp %h/%h", if_pc, if_data, exp, ref_mem[exp]); end
        exp++;
      end
      if (c == 7) begin
        n_chk++; if (bus_en !== 1'b1 || bus_addr !== 16'h8000 || if_valid !== 1'b0) begin n_fail++; $display("FAIL rd_target got %b/%h/%b exp 1/8000/0", bus_en, bus_addr, if_valid); end
      end
      if (c == 8) begin
        n_chk++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rd_dropped got %b exp 0", if_valid); end
      end
      if (c == 9) begin
        n_chk++; if (if_valid !== 1'b1 || if_pc !== 16'h8000) begin n_fail++; $display("FAIL rd_first got %b/%h exp 1/8000", if_valid, if_pc); end
      end
      @(negedge clk);
    end
    n_chk++; if (exp !== 16'h8004) begin n_fail++; $display("FAIL rd_popped got %h exp 8004", exp); end
    drive_idle();
  endtask

  task automatic test_wrap();
    logic [15:0] exp;
    do_reset();
    if_ready = 1; exp = 16'h0000; pc_new = 16'hFFFE;
    for (int c = 0; c < 9; c++) begin
      pc_load = (c == 0);
      #1;
      if (c == 0) begin
        n_chk++; if (bus_en !== 1'b0) begin n_fail++; $display("FAIL wr_load_en got %b exp 0", bus_en); end
        exp = 16'hFFFE;
      end else if (if_valid) begin
        n_chk++; if (if_pc !== exp || if_data !== ref_mem[exp]) begin n_fail++; $display("FAIL wr_stream got %h/%h exp %h/%h", if_pc, if_data, exp, ref_mem[exp]); end
        exp++;
      end
      if (c == 3) begin
        n_chk++; if (bus_en !== 1'b1 || bus_addr !== 16'h0000) begin n_fail++; $display("FAIL wr_addr got %b/%h exp 1/0000", bus_en, bus_addr); end
      end
      if (c == 4) begin
        n_chk++; if (if_pc !== 16'hFFFF) begin n_fail++; $display("FAIL wr_pc_ffff got %h exp ffff", if_pc); end
      end
      if (c == 5) begin
        n_chk++; if (if_pc !== 16'h0000) begin n_fail++; $display("FAIL wr_pc_0000 got %h exp 0000", if_pc); end
      end
      @(negedge clk);
    end
    n_chk++; if (exp !== 16'h0004) begin n_fail++; $display("FAIL wr_popped got %h exp 0004", exp); end
    drive_idle();
  endtask

`ifdef CPU_BUS_RSTVEC_EN
  task automatic test_vector();
    drive_idle();
    mem[16'hFFFC] = 8'h34; mem[16'hFFFD] = 8'h12;
    ls_req = 1; ls_we = 0; ls_addr = 16'h0201;
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1;
    for (int c = 0; c < 6; c++) begin
      ls_req = (c <= 4);
      pc_load = (c <= 1); pc_new = 16'h4000;
      #1;
      if (c == 0) begin
        n_chk++; if (bus_en !== 1'b1 || bus_addr !== 16'hFFFC || bus_rw_n !== 1'b1) begin n_fail++; $display("FAIL vec_lo got %b/%h/%b exp 1/fffc/1", bus_en, bus_addr, bus_rw_n); end
      end
      if (c == 1) begin
        n_chk++; if (bus_en !== 1'b1 || bus_addr !== 16'hFFFD) begin n_fail++; $display("FAIL vec_hi got %b/%h exp 1/fffd", bus_en, bus_addr); end
      end
      if (c == 2) begin
        n_chk++; if (bus_en !== 1'b0) begin n_fail++; $display("FAIL vec_cap_en got %b exp 0", bus_en); end
      end
      if (c == 3) begin
        n_chk++; if (bus_en !== 1'b1 || bus_addr !== 16'h0201 || bus_rw_n !== 1'b1) begin n_fail++; $display("FAIL vec_ls got %b/%h/%b exp 1/0201/1", bus_en, bus_addr, bus_rw_n); end
      end
      if (c == 4) begin
        n_chk++; if (ls_ack !== 1'b1 || ls_rdata !== ref_mem[16'h0201]) begin n_fail++; $display("FAIL vec_ld got %b/%h exp 1/%h", ls_ack, ls_rdata, ref_mem[16'h0201]); end
        n_chk++; if (bus_en !== 1'b1 || bus_addr !== 16'h1234) begin n_fail++; $display("FAIL vec_fetch got %b/%h exp 1/1234", bus_en, bus_addr); end
      end
      @(negedge clk);
    end
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h00;
    drive_idle();
  endtask
`endif

  task automatic test_random();
    logic [15:0] exp;
    int          age, pops;
    logic        done;
    do_reset();
    exp = 16'h0000; age = 0; pops = 0; done = 0;
    for (int c = 0; c < 3000; c++) begin
      if_ready = ($urandom_range(0, 3) != 0);
      pc_load = (c == 0) || ($urandom_range(0, 63) == 0);
      pc_new = (c == 0) ? 16'h1000 : 16'($urandom_range(16'h1000, 16'h7000));
      if (done) begin
        ls_req = 0; done = 0;
      end else if (!ls_req && $urandom_range(0, 3) == 0) begin
        ls_req = 1; age = 0;
        ls_we = 1'($urandom_range(0, 1));
        ls_addr = 16'h0300 + 16'($urandom_range(0, 255));
        ls_wdata = 8'($urandom_range(0, 255));
      end
      #1;
      if (ls_req && age == 0) begin
        n_chk++; if (ls_ack !== 1'b0 || bus_en !== 1'b1 || bus_addr !== ls_addr || bus_rw_n !== !ls_we) begin n_fail++; $display("FAIL rnd_ls_issue got %b/%b/%h/%b exp 0/1/%h/%b", ls_ack, bus_en, bus_addr, bus_rw_n, ls_addr, !ls_we); end
        if (ls_we) begin
          n_chk++; if (bus_wdata !== ls_wdata) begin n_fail++; $display("FAIL rnd_wdata got %h exp %h", bus_wdata, ls_wdata); end
        end
        age = 1;
      end else if (ls_req) begin
        n_chk++; if (ls_ack !== 1'b1) begin n_fail++; $display("FAIL rnd_ls_ack got %b exp 1", ls_ack); end
        if (ls_we) ref_mem[ls_addr] = ls_wdata;
        else begin
          n_chk++; if (ls_rdata !== ref_mem[ls_addr]) begin n_fail++; $display("FAIL rnd_ld_data got %h exp %h", ls_rdata, ref_mem[ls_addr]); end
        end
        done = 1;
      end else begin
        n_chk++; if (ls_ack !== 1'b0) begin n_fail++; $display("FAIL rnd_spurious_ack got %b exp 0", ls_ack); end
      end
      if (pc_load) begin
        if (!(ls_req && !done)) begin
          n_chk++; if (bus_en !== 1'b0) begin n_fail++; $display("FAIL rnd_load_en got %b exp 0", bus_en); end
        end
        exp = pc_new;
      end else if (if_valid && if_ready) begin
        n_chk++; if (if_pc !== exp || if_data !== ref_mem[exp]) begin n_fail++; $display("FAIL rnd_stream got %h/%h exp %h/%h", if_pc, if_data, exp, ref_mem[exp]); end
        exp++; pops++;
      end
      @(negedge clk);
    end
    n_chk++; if (pops < 500) begin n_fail++; $display("FAIL rnd_progress got %0d exp >=500", pops); end
    drive_idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    mem_init();
    drive_idle();
    rdq = 8'h00;
    test_reset();
`ifdef CPU_BUS_RSTVEC_EN
    test_vector();
`endif
    test_stream();
    test_backpressure();
    test_ls();
    test_redirect();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
